// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
//   ic_state_t : refill controller state
//   ic_off_w   : byte-offset width of a line (word select + 2 byte bits)
//   ic_idx_w   : line-index width
//   ic_tag_w   : tag width, whatever address bits remain above index and offset
package icache_pkg;

  typedef enum logic [0:0] {IC_IDLE, IC_REFILL} ic_state_t;

  localparam int unsigned IC_WORD_BITS = 32;

  function automatic int unsigned ic_off_w(input int unsigned words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int unsigned ic_idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned ic_tag_w(input int unsigned addr_width,
                                           input int unsigned lines,
                                           input int unsigned words_per_line);
    return addr_width - ic_idx_w(lines) - ic_off_w(words_per_line);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the instruction cache: tag RAM, valid vector and data RAM.
//   clk, rst        : clock, synchronous active-low reset (clears valid bits only)
//   rd_idx/rd_word  : asynchronous lookup port -> rd_tag, rd_valid, rd_data
//   wr_idx          : line targeted by every write/clear below
//   wr_en/wr_word   : write one data word of the line
//   tag_wr_en       : write the tag and mark the line valid
//   line_clr_en     : drop the valid bit of one line
//   clr_all         : drop every valid bit (wins over the single-line controls)
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TAG_W          = 24
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ic_idx_w(LINES)-1:0]             rd_idx,
  input  logic [ic_off_w(WORDS_PER_LINE)-3:0]    rd_word,
  output logic [TAG_W-1:0]                       rd_tag,
  output logic                                   rd_valid,
  output logic [IC_WORD_BITS-1:0]                rd_data,
  input  logic [ic_idx_w(LINES)-1:0]             wr_idx,
  input  logic                                   wr_en,
  input  logic [ic_off_w(WORDS_PER_LINE)-3:0]    wr_word,
  input  logic [IC_WORD_BITS-1:0]                wr_data,
  input  logic                                   tag_wr_en,
  input  logic [TAG_W-1:0]                       wr_tag,
  input  logic                                   line_clr_en,
  input  logic                                   clr_all
);

  logic [IC_WORD_BITS-1:0] data_mem [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [LINES-1:0]        valid_q, valid_d;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_word];

  always_comb begin
    valid_d = valid_q;
    if (line_clr_en) valid_d[wr_idx] = 1'b0;
    if (tag_wr_en)   valid_d[wr_idx] = 1'b1;
    if (clr_all)     valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en)     data_mem[wr_idx][wr_word] <= wr_data;
    if (tag_wr_en) tag_mem[wr_idx]           <= wr_tag;
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between the fetch PC and a word-wide memory.
//   clk, rst              : clock, synchronous active-low reset
//   cpu_addr              : fetch byte address; bits [1:0] ignored
//   invalidate            : one-cycle pulse flushing every line
//   cpu_rdata, cpu_stall  : instruction word, valid whenever cpu_stall==0
//   mem_req, mem_addr     : refill read request and word-aligned address
//   mem_ready, mem_rdata  : beat accepted, returned word
//   hit_count, miss_count : saturating performance counters
// Hits are answered combinationally; a miss stalls the same cycle and refills the
// whole line one beat at a time before the lookup is retried.
module instr_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    invalidate,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int unsigned OFF_W  = ic_off_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = ic_idx_w(LINES);
  localparam int unsigned TAG_W  = ic_tag_w(ADDR_WIDTH, LINES, WORDS_PER_LINE);
  localparam int unsigned WORD_W = OFF_W - 2;
  localparam int unsigned LINE_W = ADDR_WIDTH - OFF_W;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [IDX_W-1:0]  lk_idx;
  logic [WORD_W-1:0] lk_word;
  logic [TAG_W-1:0]  lk_tag;
  logic              unused_byte_bits;

  assign lk_idx           = cpu_addr[OFF_W +: IDX_W];
  assign lk_word          = cpu_addr[2 +: WORD_W];
  assign lk_tag           = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_byte_bits = ^cpu_addr[1:0];

  ic_state_t         state_q, state_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              inval_pend_q, inval_pend_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic [TAG_W-1:0]  arr_tag;
  logic              arr_valid;
  logic [31:0]       arr_data;
  logic              hit;
  logic              stall, req;
  logic              data_we, tag_we, line_clr, clr_all;
  logic [IDX_W-1:0]  wr_idx;

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (lk_idx),
    .rd_word     (lk_word),
    .rd_tag      (arr_tag),
    .rd_valid    (arr_valid),
    .rd_data     (arr_data),
    .wr_idx      (wr_idx),
    .wr_en       (data_we),
    .wr_word     (beat_q),
    .wr_data     (mem_rdata),
    .tag_wr_en   (tag_we),
    .wr_tag      (line_q[LINE_W-1:IDX_W]),
    .line_clr_en (line_clr),
    .clr_all     (clr_all)
  );

  assign hit = arr_valid && (arr_tag == lk_tag);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    inval_pend_d = inval_pend_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    stall        = 1'b0;
    req          = 1'b0;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    line_clr     = 1'b0;
    clr_all      = 1'b0;
    wr_idx       = line_q[IDX_W-1:0];
    case (state_q)
      IC_IDLE: begin
        if (invalidate || inval_pend_q) begin
          // Flush cycle: no lookup and no counting, the fetch simply waits.
          clr_all      = 1'b1;
          stall        = 1'b1;
          inval_pend_d = 1'b0;
        end else if (hit) begin
          hit_count_d = sat_inc(hit_count_q);
        end else begin
          // The victim line goes invalid now so it never looks resident half-written.
          stall        = 1'b1;
          line_d       = cpu_addr[ADDR_WIDTH-1:OFF_W];
          beat_d       = '0;
          miss_count_d = sat_inc(miss_count_q);
          line_clr     = 1'b1;
          wr_idx       = lk_idx;
          state_d      = IC_REFILL;
        end
      end
      IC_REFILL: begin
        // Refill always runs to completion; a flush request is deferred.
        req   = 1'b1;
        stall = 1'b1;
        if (invalidate) inval_pend_d = 1'b1;
        if (mem_ready) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) begin
            tag_we  = 1'b1;
            state_d = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IC_IDLE;
      beat_q       <= '0;
      inval_pend_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      inval_pend_q <= inval_pend_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  // Outputs are forced quiet while reset is held, which also drops an in-flight request.
  assign cpu_stall  = rst & stall;
  assign mem_req    = rst & req;
  assign mem_addr   = (rst && req) ? {line_q, beat_q, 2'b00} : '0;
  assign cpu_rdata  = rst ? arr_data : 32'd0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
